signed_seq_multiplier_top: RTL and testbench

- Board-level top of an 8-bit signed sequential multiplier.
- Captures two's-complement operands on a start button press, then multiplies their magnitudes by shift-and-add. The multiplier advances one iteration per rising edge of a slow step input `signal_in`.
- Presents the result as a 15-bit magnitude plus a sign bit, with an LED showing completion.

---
 rtl/signed_seq_multiplier_top.sv | 116 +++++++++++
 tb/tb_signed_seq_multiplier_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/signed_seq_multiplier_top.sv
// Board-level 8-bit signed sequential multiplier.
// Operands are captured on a start button press. Their magnitudes are then
// multiplied by shift-and-add, one iteration per rising edge of signal_in.
// The result is a 15-bit magnitude plus a sign bit.
module signed_seq_multiplier_top (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        signal_in,
  input  logic        BTNC,
  input  logic [7:0]  multiplier,
  input  logic [7:0]  multiplicand,
  output logic [14:0] product,
  output logic        sign,
  output logic        load,
  output logic        led
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t      state, state_next;
  logic        sig_s1, sig_s2, sig_d;
  logic        btn_s1, btn_s2, btn_d;
  logic        step, start;
  logic [7:0]  mag_a, mag_b;
  logic        sgn;
  logic [15:0] acc, acc_next, addend;
  logic [2:0]  cnt;
  logic        last_step;

  // Two-flop synchronizers plus registered edge-detect history for both async inputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sig_s1 <= 1'b0; sig_s2 <= 1'b0; sig_d <= 1'b0;
      btn_s1 <= 1'b0; btn_s2 <= 1'b0; btn_d <= 1'b0;
    end else begin
      sig_s1 <= signal_in; sig_s2 <= sig_s1; sig_d <= sig_s2;
      btn_s1 <= BTNC;      btn_s2 <= btn_s1; btn_d <= btn_s2;
    end
  end

  assign step  = sig_s2 & ~sig_d;
  assign start = btn_s2 & ~btn_d;

  // One shift-and-add iteration: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    addend    = {8'h00, mag_a} << cnt;
    acc_next  = mag_b[0] ? acc + addend : acc;
    last_step = (cnt == 3'd7);
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    load       = 1'b0;
    led        = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN:  if (step && last_step) state_next = DONE;
      DONE: begin
        led = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers.
  // The result is latched on the final step so it is already valid when DONE is entered,
  // and it is cleared as LOAD is entered so a stale result never shows during LOAD.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mag_a   <= '0;
      mag_b   <= '0;
      sgn     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      sign    <= 1'b0;
    end else begin
      if (state_next == LOAD) begin
        product <= '0;
        sign    <= 1'b0;
      end
      case (state)
        LOAD: begin
          mag_a <= multiplicand[7] ? 8'(-multiplicand) : multiplicand;
          mag_b <= multiplier[7]   ? 8'(-multiplier)   : multiplier;
          sgn   <= multiplicand[7] ^ multiplier[7];
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: if (step) begin
          acc   <= acc_next;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + 3'd1;
          if (last_step) begin
            product <= acc_next[14:0];
            sign    <= sgn & (acc_next != 16'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_multiplier_top.sv
module tb_signed_seq_multiplier_top;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        signal_in = 1'b0;
  logic        BTNC = 1'b0;
  logic [7:0]  multiplier = '0;
  logic [7:0]  multiplicand = '0;
  logic [14:0] product;
  logic        sign;
  logic        load;
  logic        led;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;

  signed_seq_multiplier_top dut (
    .sys_clk(sys_clk), .rst(rst), .signal_in(signal_in), .BTNC(BTNC),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .product(product), .sign(sign), .load(load), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (load === 1'b1) load_cnt++;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One step strobe: 100 ns period
  task automatic pulse_step();
    signal_in = 1'b1; wait_cyc(5);
    signal_in = 1'b0; wait_cyc(5);
  endtask

  task automatic press_start();
    BTNC = 1'b1; wait_cyc(4);
    BTNC = 1'b0; wait_cyc(4);
  endtask

  // Reference: signed product by plain integer arithmetic
  task automatic model(input logic signed [7:0] a, input logic signed [7:0] b,
                       output int p, output logic s);
    int r;
    r = int'(a) * int'(b);
    p = (r < 0) ? -r : r;
    s = (r < 0);
  endtask

  task automatic do_mult(input logic signed [7:0] a, input logic signed [7:0] b, input string name);
    int p; logic s; int t; int l0;
    model(a, b, p, s);
    multiplicand = a; multiplier = b;
    l0 = load_cnt;
    press_start();
    tests++;
    if (led !== 1'b0 || product !== 15'd0) begin
      fails++;
      $display("FAIL %s run_state led=%b product=%0d required led=0 product=0", name, led, product);
    end
    for (int i = 0; i < 8; i++) pulse_step();
    t = 0;
    while (led !== 1'b1 && t < 20) begin wait_cyc(1); t++; end
    tests++;
    if (led !== 1'b1) begin
      fails++; $display("FAIL %s led_timeout led=%b required 1", name, led);
    end
    tests++;
    if (product !== 15'(p)) begin
      fails++; $display("FAIL %s product got %0d required %0d (a=%0d b=%0d)", name, product, p, a, b);
    end
    tests++;
    if (sign !== s) begin
      fails++; $display("FAIL %s sign got %b required %b (a=%0d b=%0d)", name, sign, s, a, b);
    end
    tests++;
    if (load_cnt - l0 !== 1) begin
      fails++; $display("FAIL %s load_pulses got %0d required 1", name, load_cnt - l0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_cyc(3); rst = 1'b0; wait_cyc(1);
    tests++;
    if (product !== 15'd0 || sign !== 1'b0 || load !== 1'b0 || led !== 1'b0) begin
      fails++;
      $display("FAIL reset product=%0d sign=%b load=%b led=%b required all 0", product, sign, load, led);
    end
  endtask

  task automatic test_idle_steps();
    for (int i = 0; i < 3; i++) pulse_step();
    tests++;
    if (led !== 1'b0 || product !== 15'd0 || load_cnt !== 0) begin
      fails++;
      $display("FAIL idle_steps led=%b product=%0d loads=%0d required 0 0 0", led, product, load_cnt);
    end
  endtask

  task automatic test_directed();
    do_mult(8'sd127, 8'sd127, "p127x127");
    do_mult(8'sd0, 8'sd5, "p0x5");
    do_mult(-8'sd7, 8'sd6, "m7x6");
  endtask

  task automatic test_hold();
    multiplicand = 8'd8; multiplier = 8'd6;
    for (int i = 0; i < 3; i++) pulse_step();
    tests++;
    if (product !== 15'd42 || sign !== 1'b1 || led !== 1'b1) begin
      fails++;
      $display("FAIL hold product=%0d sign=%b led=%b required 42 1 1", product, sign, led);
    end
  endtask

  task automatic test_boundary();
    do_mult(8'sd8, 8'sd6, "p8x6");
    do_mult(-8'sd128, -8'sd128, "m128xm128");
    do_mult(-8'sd128, 8'sd1, "m128x1");
    do_mult(8'sd127, -8'sd128, "p127xm128");
    do_mult(-8'sd5, 8'sd0, "m5x0");
  endtask

  task automatic test_reset_mid_run();
    multiplicand = 8'd5; multiplier = 8'd3;
    press_start();
    for (int i = 0; i < 4; i++) pulse_step();
    rst = 1'b1; wait_cyc(1); rst = 1'b0;
    tests++;
    if (product !== 15'd0 || sign !== 1'b0 || load !== 1'b0 || led !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run product=%0d sign=%b load=%b led=%b required all 0", product, sign, load, led);
    end
    for (int i = 0; i < 8; i++) pulse_step();
    wait_cyc(5);
    tests++;
    if (product !== 15'd0 || led !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_steps product=%0d led=%b required 0 0", product, led);
    end
  endtask

  task automatic test_random();
    logic signed [7:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_mult(a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_idle_steps();
    test_directed();
    test_hold();
    test_boundary();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
